disp_vramarb: RTL and testbench
===============================

Name: disp_vramarb

Overview:
- Two-requester arbiter for the single AXI read port into VRAM.
- Requester 0 (M0) is the display VRAM reader and is real-time, so it has high priority. Requester 1 (M1) is a secondary reader, such as a draw/blit engine, and has low priority.
- Grants one burst at a time, drives the shared AR channel, and routes the R channel back to the owner until RLAST.
- Sits between the requesters and the AXI interconnect slave port.

Parameters:
- AW, 32, address width.
- DW, 32, read data width.
- STARVE_MAX, 4, consecutive M0 grants allowed while M1 waits before M1 is forced (used only with the optional feature).

Ports:
- ACLK  in  1  system clock; all logic on rising edge.
- ARST  in  1  reset; asynchronous, active-low (0 = reset).
- M0_ARADDR  in  AW  M0 burst address.
- M0_ARVALID  in  1  M0 request.
- M0_ARREADY  out  1  M0 address accepted.
- M0_RDATA  out  DW  routed read data.
- M0_RLAST  out  1  routed last beat.
- M0_RVALID  out  1  routed data valid.
- M0_RREADY  in  1  M0 data ready.
- M1_ARADDR, M1_ARVALID, M1_ARREADY, M1_RDATA, M1_RLAST, M1_RVALID, M1_RREADY: same as the M0 set, for M1.
- S_ARADDR  out  AW  address to slave.
- S_ARVALID  out  1  address valid to slave.
- S_ARREADY  in  1  slave address ready.
- S_RDATA  in  DW  slave data.
- S_RLAST  in  1  slave last beat.
- S_RVALID  in  1  slave data valid.
- S_RREADY  out  1  ready to slave.
- GRANT  out  2  one-hot owner of the current burst; 00 when idle.

Behaviour:
- Reset (ARST=0, asynchronous):
  - state=S_IDLE, GRANT=00, S_ARVALID=0, S_ARADDR=0, S_RREADY=0.
  - All M*_ARREADY, M*_RVALID and M*_RLAST are 0; starvation counter is 0.
  - Reset mid-burst abandons the burst immediately. There is no drain and no error flag.
- State S_IDLE:
  - Sample M0_ARVALID and M1_ARVALID.
  - If both are asserted, grant M0 (unless the starvation rule applies). If only one is asserted, grant it.
  - On a grant: latch the owner into GRANT, latch the owner's ARADDR into S_ARADDR, and go to S_ADDR.
  - If neither is asserted, stay in S_IDLE.
- State S_ADDR:
  - S_ARVALID=1, with S_ARADDR held from the latch.
  - Owner's M*_ARREADY = S_ARREADY (combinational). The non-owner's ARREADY is 0.
  - On S_ARVALID & S_ARREADY, go to S_DATA; S_ARVALID falls in the next cycle.
  - S_ARVALID is never dropped before the handshake.
- State S_DATA:
  - Owner gets M*_RDATA/RLAST/RVALID = S_RDATA/RLAST/RVALID, and S_RREADY = owner's M*_RREADY.
  - Non-owner gets RVALID=0, RLAST=0 and RDATA=0.
  - On S_RVALID & S_RREADY & S_RLAST, go to S_IDLE and set GRANT to 00 in the next cycle.
- Timing:
  - Minimum request-to-S_ARVALID latency is 1 cycle.
  - Minimum gap between bursts is 1 idle cycle; back-to-back bursts are not overlapped.
  - Only one outstanding burst at a time; burst length is the slave's concern.
- Requester contract: a requester holds ARVALID and ARADDR until its ARREADY. A request dropped while in S_IDLE is simply not granted.
- Simultaneous events:
  - A new request arriving in the same cycle as RLAST is evaluated in the following S_IDLE cycle.
  - Requests arriving in S_ADDR or S_DATA wait.
- Unused master RDATA outputs are driven to 0, not X.

Optional Feature:
- Macro: DISP_VRAMARB_STARVE_EN.
- Defined:
  - A 4-bit counter increments on every M0 grant made while M1_ARVALID=1, saturating at STARVE_MAX.
  - While the count equals STARVE_MAX and both requesters are asserted in S_IDLE, M1 is granted instead.
  - The counter clears on any M1 grant, or on an M0 grant made while M1_ARVALID=0.
- Undefined: strict priority. M0 always wins, no counter logic is present, and M1 may starve indefinitely.

Test Plan:
- Only M1 requests, addr 0x1000_0040; slave ARREADY after 3 cycles; 8-beat burst -> GRANT=10, S_ARADDR=0x1000_0040, M1_ARREADY pulses once, M1 receives 8 beats with RLAST on beat 8, M0_RVALID stays 0.
- Both request in the same cycle, addresses 0x0 and 0x2000 -> M0 granted first (GRANT=01). After M0's RLAST there is 1 idle cycle, then M1 is granted with S_ARADDR=0x2000.
- M0_RREADY held low for 5 cycles mid-burst -> S_RREADY=0 for those cycles, no beats lost, burst completes with the correct beat count.
- STARVE_EN defined, STARVE_MAX=4, M0 and M1 both continuously requesting -> grant sequence 01,01,01,01,10,01,01,01,01,10. Without the macro, all grants are 01.
- ARST asserted low during beat 3 of an M0 burst -> all outputs at their reset values asynchronously. After release, a fresh M1 request is granted normally.
- RLAST handshake in the same cycle as a new M1_ARVALID rise -> M1 is granted in the following S_IDLE cycle, and S_ARVALID rises 2 cycles after RLAST.

Source files
------------

// File: rtl/disp_vramarb.sv
// Two-requester read arbiter for the shared VRAM AXI AR/R port: M0 (display) has priority, M1 is secondary.
// Optional macro DISP_VRAMARB_STARVE_EN forces an M1 grant after STARVE_MAX consecutive M0 wins while M1 waits.
module disp_vramarb #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          ACLK,
    input  logic          ARST,
    input  logic [AW-1:0] M0_ARADDR,
    input  logic          M0_ARVALID,
    output logic          M0_ARREADY,
    output logic [DW-1:0] M0_RDATA,
    output logic          M0_RLAST,
    output logic          M0_RVALID,
    input  logic          M0_RREADY,
    input  logic [AW-1:0] M1_ARADDR,
    input  logic          M1_ARVALID,
    output logic          M1_ARREADY,
    output logic [DW-1:0] M1_RDATA,
    output logic          M1_RLAST,
    output logic          M1_RVALID,
    input  logic          M1_RREADY,
    output logic [AW-1:0] S_ARADDR,
    output logic          S_ARVALID,
    input  logic          S_ARREADY,
    input  logic [DW-1:0] S_RDATA,
    input  logic          S_RLAST,
    input  logic          S_RVALID,
    output logic          S_RREADY,
    output logic [1:0]    GRANT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [1:0]    grant_r;
    logic [AW-1:0] araddr_r;
    logic          arvalid_r;
    logic          grant_new_s;
    logic          pick_m1_s;
    logic          starve_force_s;
    logic          rready_s;
    logic          rlast_hs_s;

    // The starvation counter is 4 bits wide, so the limit must fit in it.
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_max_unsupported
    end

    assign grant_new_s = (state_r == S_IDLE) && (M0_ARVALID || M1_ARVALID);
    assign rlast_hs_s  = S_RVALID && rready_s && S_RLAST;

`ifdef DISP_VRAMARB_STARVE_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0] starve_cnt_r;

    assign starve_force_s = (starve_cnt_r == STARVE_LIM);

    // Count M0 wins taken while M1 was waiting; any M1 win or uncontested M0 win clears it.
    always_ff @(posedge ACLK or negedge ARST) begin
        if (!ARST) begin
            starve_cnt_r <= 4'd0;
        end else if (grant_new_s) begin
            if (pick_m1_s) begin
                starve_cnt_r <= 4'd0;
            end else if (M1_ARVALID) begin
                starve_cnt_r <= (starve_cnt_r == STARVE_LIM) ? starve_cnt_r : starve_cnt_r + 4'd1;
            end else begin
                starve_cnt_r <= 4'd0;
            end
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    assign starve_force_s = 1'b0;
`endif

    // Winner selection among the requests sampled in S_IDLE.
    always_comb begin
        pick_m1_s = 1'b0;
        if (M0_ARVALID && M1_ARVALID) begin
            pick_m1_s = starve_force_s;
        end else if (M1_ARVALID) begin
            pick_m1_s = 1'b1;
        end else begin
            pick_m1_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge ACLK or negedge ARST) begin
        if (!ARST) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: one burst at a time, always passing through S_IDLE between bursts.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (grant_new_s) begin
                    state_nxt_s = S_ADDR;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ADDR: begin
                if (arvalid_r && S_ARREADY) begin
                    state_nxt_s = S_DATA;
                end else begin
                    state_nxt_s = S_ADDR;
                end
            end
            S_DATA: begin
                if (rlast_hs_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DATA;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Owner, latched address and AR valid, all held for the life of the burst.
    always_ff @(posedge ACLK or negedge ARST) begin
        if (!ARST) begin
            grant_r   <= 2'b00;
            araddr_r  <= {AW{1'b0}};
            arvalid_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (grant_new_s) begin
                        grant_r   <= pick_m1_s ? 2'b10 : 2'b01;
                        araddr_r  <= pick_m1_s ? M1_ARADDR : M0_ARADDR;
                        arvalid_r <= 1'b1;
                    end else begin
                        grant_r   <= 2'b00;
                        arvalid_r <= 1'b0;
                    end
                end
                S_ADDR: begin
                    if (S_ARREADY) begin
                        arvalid_r <= 1'b0;
                    end else begin
                        arvalid_r <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (rlast_hs_s) begin
                        grant_r <= 2'b00;
                    end else begin
                        grant_r <= grant_r;
                    end
                end
                default: begin
                    grant_r   <= 2'b00;
                    arvalid_r <= 1'b0;
                end
            endcase
        end
    end

    // Output routing: AR ready and R channel go only to the current owner; everything else reads 0.
    always_comb begin
        M0_ARREADY = 1'b0;
        M1_ARREADY = 1'b0;
        M0_RVALID  = 1'b0;
        M0_RLAST   = 1'b0;
        M0_RDATA   = {DW{1'b0}};
        M1_RVALID  = 1'b0;
        M1_RLAST   = 1'b0;
        M1_RDATA   = {DW{1'b0}};
        rready_s   = 1'b0;
        case (state_r)
            S_ADDR: begin
                M0_ARREADY = grant_r[0] & S_ARREADY;
                M1_ARREADY = grant_r[1] & S_ARREADY;
            end
            S_DATA: begin
                M0_RVALID = grant_r[0] & S_RVALID;
                M0_RLAST  = grant_r[0] & S_RLAST;
                M0_RDATA  = grant_r[0] ? S_RDATA : {DW{1'b0}};
                M1_RVALID = grant_r[1] & S_RVALID;
                M1_RLAST  = grant_r[1] & S_RLAST;
                M1_RDATA  = grant_r[1] ? S_RDATA : {DW{1'b0}};
                rready_s  = (grant_r[0] & M0_RREADY) | (grant_r[1] & M1_RREADY);
            end
            default: begin
                rready_s = 1'b0;
            end
        endcase
    end

    assign S_ARADDR  = araddr_r;
    assign S_ARVALID = arvalid_r;
    assign S_RREADY  = rready_s;
    assign GRANT     = grant_r;

endmodule

// File: tb/tb_disp_vramarb.sv
// Randomized bench for disp_vramarb against a transaction-level model of the arbitration rules.
module tb_disp_vramarb;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;
`ifdef DISP_VRAMARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic          ACLK = 1'b0;
    logic          ARST = 1'b0;
    logic [AW-1:0] M0_ARADDR = '0, M1_ARADDR = '0, S_ARADDR;
    logic          M0_ARVALID = 1'b0, M1_ARVALID = 1'b0, M0_ARREADY, M1_ARREADY;
    logic [DW-1:0] M0_RDATA, M1_RDATA, S_RDATA = '0;
    logic          M0_RLAST, M1_RLAST, M0_RVALID, M1_RVALID;
    logic          M0_RREADY = 1'b0, M1_RREADY = 1'b0;
    logic          S_ARVALID, S_ARREADY = 1'b0, S_RLAST = 1'b0, S_RVALID = 1'b0, S_RREADY;
    logic [1:0]    GRANT;

    always #5 ACLK = ~ACLK;

    disp_vramarb #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .ACLK(ACLK), .ARST(ARST),
        .M0_ARADDR(M0_ARADDR), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
        .M0_RDATA(M0_RDATA), .M0_RLAST(M0_RLAST), .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
        .M1_ARADDR(M1_ARADDR), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
        .M1_RDATA(M1_RDATA), .M1_RLAST(M1_RLAST), .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
        .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RDATA(S_RDATA), .S_RLAST(S_RLAST), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
        .GRANT(GRANT)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: burst owner (0 none, 1 M0, 2 M1) and which half of the burst is open.
    int            own;
    bit            addr_ph, data_ph;
    logic [AW-1:0] exp_addr;
    int            streak;
    bit            pend [2];
    logic [AW-1:0] raddr [2];
    int            grants [2];
    int            slv_left, slv_len, rx_cnt;
    bit            slv_rv;
    logic [DW-1:0] slv_data;
    int            p_req [2];
    int            len_fix;
    bit            addr1_fix;

    task automatic model_clear();
        own = 0; addr_ph = 0; data_ph = 0; streak = 0;
        slv_left = 0; slv_len = 0; rx_cnt = 0; slv_rv = 0;
        for (int m = 0; m < 2; m++) begin
            pend[m] = 0; grants[m] = 0;
        end
    endtask

    task automatic drive();
        for (int m = 0; m < 2; m++) begin
            if (!pend[m] && $urandom_range(0, 99) < p_req[m]) begin
                pend[m]  = 1;
                raddr[m] = (m == 1 && addr1_fix) ? 32'h1000_0040 : ($urandom & 32'hFFFF_FFC0);
            end
        end
        M0_ARVALID = pend[0]; M0_ARADDR = raddr[0];
        M1_ARVALID = pend[1]; M1_ARADDR = raddr[1];
        S_ARREADY  = ($urandom_range(0, 2) == 0);
        if (slv_left > 0 && !slv_rv && $urandom_range(0, 1) == 1) begin
            slv_rv   = 1;
            slv_data = $urandom;
        end
        S_RVALID  = slv_rv;
        S_RLAST   = slv_rv ? (slv_left == 1) : 1'($urandom_range(0, 1));
        S_RDATA   = slv_rv ? slv_data : $urandom;
        M0_RREADY = ($urandom_range(0, 3) != 0);
        M1_RREADY = ($urandom_range(0, 3) != 0);
    endtask

    task automatic check_cycle();
        bit o0, o1;
        o0 = data_ph && own == 1;
        o1 = data_ph && own == 2;
        check_val("grant", GRANT, (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00);
        check_val("s_arvalid", S_ARVALID, addr_ph);
        if (addr_ph) check_val("s_araddr", S_ARADDR, exp_addr);
        check_val("m0_arready", M0_ARREADY, addr_ph && own == 1 && S_ARREADY);
        check_val("m1_arready", M1_ARREADY, addr_ph && own == 2 && S_ARREADY);
        check_val("s_rready", S_RREADY, (o0 && M0_RREADY) || (o1 && M1_RREADY));
        check_val("m0_rvalid", M0_RVALID, o0 && S_RVALID);
        check_val("m1_rvalid", M1_RVALID, o1 && S_RVALID);
        check_val("m0_rlast", M0_RLAST, o0 && S_RLAST);
        check_val("m1_rlast", M1_RLAST, o1 && S_RLAST);
        check_val("m0_rdata", M0_RDATA, o0 ? S_RDATA : 32'h0);
        check_val("m1_rdata", M1_RDATA, o1 ? S_RDATA : 32'h0);
    endtask

    // Advance the model across the coming rising edge using the inputs held this cycle.
    task automatic update();
        bit rr;
        int win;
        rr = (data_ph && own == 1 && M0_RREADY) || (data_ph && own == 2 && M1_RREADY);
        if ((M0_RVALID && M0_RREADY) || (M1_RVALID && M1_RREADY)) rx_cnt++;
        if (!addr_ph && !data_ph) begin
            if (pend[0] || pend[1]) begin
                if (pend[0] && pend[1]) win = (STARVE_ON && streak == SMAX) ? 2 : 1;
                else win = pend[0] ? 1 : 2;
                if (win == 1) streak = pend[1] ? ((streak < SMAX) ? streak + 1 : SMAX) : 0;
                else streak = 0;
                own = win; exp_addr = raddr[win-1]; addr_ph = 1; grants[win-1]++;
            end
        end else if (addr_ph) begin
            if (S_ARREADY) begin
                addr_ph = 0; data_ph = 1; pend[own-1] = 0;
                slv_len = (len_fix > 0) ? len_fix : $urandom_range(1, 8);
                slv_left = slv_len; rx_cnt = 0;
            end
        end else if (S_RVALID && rr) begin
            slv_left--; slv_rv = 0;
            if (S_RLAST) begin
                check_val("beat_count", rx_cnt, slv_len);
                data_ph = 0; own = 0;
            end
        end
    endtask

    task automatic step();
        @(negedge ACLK);
        drive();
        #1;
        check_cycle();
        update();
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        #3;
        ARST = 1'b0;
        M0_ARVALID = 0; M1_ARVALID = 0; S_RVALID = 0; S_RLAST = 0; S_ARREADY = 0;
        #1;
        check_val("rst_grant", GRANT, 2'b00);
        check_val("rst_s_arvalid", S_ARVALID, 1'b0);
        check_val("rst_s_araddr", S_ARADDR, 32'h0);
        check_val("rst_s_rready", S_RREADY, 1'b0);
        check_val("rst_arready", {M0_ARREADY, M1_ARREADY}, 2'b00);
        check_val("rst_rvalid", {M0_RVALID, M1_RVALID, M0_RLAST, M1_RLAST}, 4'h0);
        check_val("rst_rdata", {M0_RDATA, M1_RDATA}, 64'h0);
        model_clear();
        @(negedge ACLK);
        @(negedge ACLK);
        ARST = 1'b1;
    endtask

    initial begin
        bit hit;
        model_clear();
        len_fix = 0; addr1_fix = 0; p_req[0] = 0; p_req[1] = 0;
        do_reset();

        // Lone M1 requester, fixed address and 8-beat bursts.
        p_req[1] = 100; addr1_fix = 1; len_fix = 8;
        repeat (100) step();
        check_val("m1_only_granted", grants[1] > 0, 1'b1);
        check_val("m1_only_no_m0", grants[0], 0);

        // Both requesting continuously: strict priority or periodic M1 relief.
        do_reset();
        addr1_fix = 0; len_fix = 0; p_req[0] = 100; p_req[1] = 100;
        repeat (400) step();
        check_val("contend_m1_grants", grants[1],
                  STARVE_ON ? (grants[0] + grants[1]) / (SMAX + 1) : 0);

        // Asynchronous reset during beat 3 of an M0 burst, then a fresh M1 request.
        do_reset();
        p_req[0] = 100; p_req[1] = 0; len_fix = 8;
        hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            step();
            hit = data_ph && own == 1 && rx_cnt >= 2;
        end
        check_val("reset_wait_reached", hit, 1'b1);
        do_reset();
        p_req[0] = 0; p_req[1] = 100; len_fix = 0;
        repeat (60) step();
        check_val("post_reset_m1_granted", grants[1] > 0, 1'b1);

        // Free-running random traffic.
        do_reset();
        p_req[0] = 30; p_req[1] = 30;
        repeat (3000) step();
        p_req[0] = 70; p_req[1] = 70;
        repeat (2000) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
